mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 7 +
 rtl/mem_ctrl_ram.sv | 23 ++
 rtl/mem_ctrl.sv | 68 ++++++
 tb/tb_mem_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state encoding and default parameters for the memory controller.
package mem_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 8;
  localparam int WAIT_CYCLES_DEF = 2;
endpackage

// File: rtl/mem_ctrl_ram.sv
// mem_ctrl_ram: single-port synchronous RAM with write enable and registered read port.
module mem_ctrl_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  // The array itself is never reset; only the read register is.
  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
  end
  always_ff @(posedge clock) begin
    if (reset) rdata <= '0;
    else if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: request FSM with programmable wait states in front of a single-port RAM.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done
);
  state_t state, state_n;
  logic [3:0] cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic op_q;
  logic req, we, re;
  assign req = write | read;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = req ? (WAIT_CYCLES == 0 ? ACCESS : WAIT) : IDLE;
    else if (state == WAIT) state_n = cnt == 4'd1 ? ACCESS : WAIT;
    else state_n = IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      op_q <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= state == ACCESS;
      if (state == IDLE && req) begin
        cnt <= 4'(WAIT_CYCLES);
        addr_q <= addr;
        wdata_q <= wdata;
        op_q <= write;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end
  // Reset on the ACCESS exit edge must suppress the commit.
  assign we = state == ACCESS && op_q && !reset;
  assign re = state == ACCESS && !op_q && !reset;
  mem_ctrl_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clock(clock),
    .reset(reset),
    .we(we),
    .re(re),
    .addr(addr_q),
    .wdata(wdata_q),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed checks of mem_ctrl with WAIT_CYCLES=2 (u_dut) and WAIT_CYCLES=0 (u_dut0).
module tb_mem_ctrl;
  logic clock = 0;
  logic reset = 1;
  logic write = 0, read = 0;
  logic [7:0] addr = 0;
  logic [15:0] wdata = 0;
  logic [15:0] rdata;
  logic busy, done;
  logic w0 = 0, r0 = 0;
  logic [7:0] a0 = 0;
  logic [15:0] d0 = 0;
  logic [15:0] q0;
  logic busy0, done0;
  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  mem_ctrl #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(2)) u_dut (
    .clock(clock), .reset(reset), .write(write), .read(read), .addr(addr),
    .wdata(wdata), .rdata(rdata), .busy(busy), .done(done)
  );

  mem_ctrl #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(0)) u_dut0 (
    .clock(clock), .reset(reset), .write(w0), .read(r0), .addr(a0),
    .wdata(d0), .rdata(q0), .busy(busy0), .done(done0)
  );

  task automatic req(input logic w, input logic r, input logic [7:0] a, input logic [15:0] d,
                     output int lat, output int nbusy);
    @(negedge clock);
    write = w; read = r; addr = a; wdata = d;
    @(posedge clock); #1;
    write = 0; read = 0;
    lat = 1;
    nbusy = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(posedge clock); #1;
      lat++;
      if (busy) nbusy++;
    end
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (3) @(posedge clock);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (rdata !== 16'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0000", rdata); end
    total++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin bad++; $display("FAIL reset_dut0 got=%b%b exp=00", busy0, done0); end
    @(negedge clock);
    reset = 0;
  endtask

  task automatic test_write_read;
    int lat, nb;
    req(1, 0, 8'h10, 16'hBEEF, lat, nb);
    total++; if (lat !== 4) begin bad++; $display("FAIL wr_latency got=%0d exp=4", lat); end
    total++; if (nb !== 3) begin bad++; $display("FAIL wr_busy_cycles got=%0d exp=3", nb); end
    req(0, 1, 8'h10, 16'h0, lat, nb);
    total++; if (lat !== 4) begin bad++; $display("FAIL rd_latency got=%0d exp=4", lat); end
    total++; if (rdata !== 16'hBEEF) begin bad++; $display("FAIL rd_data got=%h exp=beef", rdata); end
    @(posedge clock); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_width got=%b exp=0", done); end
    total++; if (rdata !== 16'hBEEF) begin bad++; $display("FAIL rd_hold got=%h exp=beef", rdata); end
  endtask

  task automatic test_simultaneous;
    int lat, nb;
    req(1, 1, 8'h05, 16'h1234, lat, nb);
    total++; if (rdata !== 16'hBEEF) begin bad++; $display("FAIL simul_rdata got=%h exp=beef", rdata); end
    req(0, 1, 8'h05, 16'h0, lat, nb);
    total++; if (rdata !== 16'h1234) begin bad++; $display("FAIL simul_mem got=%h exp=1234", rdata); end
  endtask

  task automatic test_ignore_busy;
    int lat, nb;
    req(1, 0, 8'hFF, 16'h7777, lat, nb);
    @(negedge clock);
    write = 1; addr = 8'h20; wdata = 16'hAAAA;
    @(posedge clock); #1;
    addr = 8'hFF; wdata = 16'h0000;
    @(posedge clock); #1;
    write = 0;
    lat = 2;
    while (!done && lat < 20) begin @(posedge clock); #1; lat++; end
    total++; if (lat !== 4) begin bad++; $display("FAIL ign_latency got=%0d exp=4", lat); end
    req(0, 1, 8'h20, 16'h0, lat, nb);
    total++; if (rdata !== 16'hAAAA) begin bad++; $display("FAIL ign_addr20 got=%h exp=aaaa", rdata); end
    req(0, 1, 8'hFF, 16'h0, lat, nb);
    total++; if (rdata !== 16'h7777) begin bad++; $display("FAIL ign_addrff got=%h exp=7777", rdata); end
  endtask

  task automatic test_reset_abort;
    int lat, nb;
    req(1, 0, 8'h30, 16'h1111, lat, nb);
    @(negedge clock);
    write = 1; addr = 8'h30; wdata = 16'h5555;
    @(posedge clock); #1;
    write = 0;
    repeat (2) @(posedge clock);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_in_access got=%b exp=1", busy); end
    reset = 1;
    @(posedge clock); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_idle got=%b exp=0", busy); end
    total++; if (rdata !== 16'h0) begin bad++; $display("FAIL abort_rdata got=%h exp=0000", rdata); end
    @(negedge clock);
    reset = 0;
    @(posedge clock); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_no_pulse got=%b exp=0", done); end
    req(0, 1, 8'h30, 16'h0, lat, nb);
    total++; if (rdata !== 16'h1111) begin bad++; $display("FAIL abort_mem got=%h exp=1111", rdata); end
  endtask

  task automatic test_back_to_back;
    @(negedge clock);
    w0 = 1; a0 = 8'h03; d0 = 16'h4242;
    @(posedge clock); #1;
    w0 = 0;
    total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL b2b_wr_busy got=%b exp=1", busy0); end
    @(posedge clock); #1;
    total++; if (done0 !== 1'b1) begin bad++; $display("FAIL b2b_wr_done got=%b exp=1", done0); end
    r0 = 1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clock); #1;
      total++;
      if (busy0 !== k[0] || done0 !== !k[0]) begin
        bad++; $display("FAIL b2b_pattern k=%0d got busy=%b done=%b exp busy=%b done=%b", k, busy0, done0, k[0], !k[0]);
      end
      if (!k[0]) begin
        total++; if (q0 !== 16'h4242) begin bad++; $display("FAIL b2b_rdata k=%0d got=%h exp=4242", k, q0); end
      end
    end
    r0 = 0;
  endtask

  task automatic test_boundary;
    int lat, nb;
    req(1, 0, 8'h00, 16'h0001, lat, nb);
    req(1, 0, 8'hFF, 16'hFFFF, lat, nb);
    req(0, 1, 8'h00, 16'h0, lat, nb);
    total++; if (rdata !== 16'h0001) begin bad++; $display("FAIL bnd_addr00 got=%h exp=0001", rdata); end
    req(0, 1, 8'hFF, 16'h0, lat, nb);
    total++; if (rdata !== 16'hFFFF) begin bad++; $display("FAIL bnd_addrff got=%h exp=ffff", rdata); end
    total++; if (lat !== 4) begin bad++; $display("FAIL bnd_latency got=%0d exp=4", lat); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_simultaneous();
    test_ignore_busy();
    test_reset_abort();
    test_back_to_back();
    test_boundary();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
